// File: rtl/count_sequencer_pkg.sv
// Shared encodings for the count sequencer: FSM states, BCD terminal counts and
// the per-cycle button command bundle.
package count_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [7:0] BCD_MAX = 8'h99;
   localparam logic [7:0] BCD_MIN = 8'h00;

   typedef struct packed {
      logic clear;
      logic start;
      logic dir;
   } btn_cmd_t;

   // Count value at which a step in the given direction would leave the 00..99 range.
   function automatic logic is_terminal(input logic up, input logic [7:0] cnt);
      return up ? (cnt == BCD_MAX) : (cnt == BCD_MIN);
   endfunction

endpackage

// File: rtl/count_sequencer_btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability filter and a single-cycle
// press pulse on each rising edge of the filtered level.
module count_sequencer_btn_debounce #(
   parameter int unsigned DEB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             db_q, db_d;
   logic             db_prev_q, db_prev_d;
   logic             press_q, press_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   // Level only follows the synchronized input after DEB_CYCLES differing samples in a row.
   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      db_d      = db_q;
      cnt_d     = '0;
      db_prev_d = db_q;
      press_d   = db_q & ~db_prev_q;
      if (sync2_q != db_q) begin
         if (cnt_q == DEB_LAST) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DEB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         press_q   <= press_d;
         cnt_q     <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/direction/clear controller for the 2-digit BCD counter: conditions the three
// buttons, generates the step strobe and sequences IDLE/RUN/PAUSE/DONE.
module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter int unsigned STEP_DIV   = 50_000_000,
   parameter int unsigned DEB_CYCLES = 500_000,
   parameter int unsigned WRAP       = 1
) (
   input  logic       clk_50MHz,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_dir,
   input  logic       btn_clear,
   input  logic [7:0] count_in,
   output logic       step_en,
   output logic       step_up,
   output logic       cnt_clr,
   output logic [1:0] state,
   output logic       run_led
);

   localparam int unsigned PRESC_W = $clog2(STEP_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

   logic     start_p, dir_p, clear_p;
   btn_cmd_t cmd;

   count_sequencer_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
      .clk     (clk_50MHz),
      .reset   (reset),
      .btn_raw (btn_start),
      .press   (start_p)
   );

   count_sequencer_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
      .clk     (clk_50MHz),
      .reset   (reset),
      .btn_raw (btn_dir),
      .press   (dir_p)
   );

   count_sequencer_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
      .clk     (clk_50MHz),
      .reset   (reset),
      .btn_raw (btn_clear),
      .press   (clear_p)
   );

   assign cmd = '{clear: clear_p, start: start_p, dir: dir_p};

   state_e               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic                 dir_q, dir_d;
   logic                 step_up_q, step_up_d;
   logic                 step_en_q, step_en_d;
   logic                 cnt_clr_q, cnt_clr_d;
   logic                 slot;
   logic                 step_ok;

   assign slot    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   assign step_ok = (WRAP != 0) || !is_terminal(dir_q, count_in);

   // Next state, prescaler and strobes; clear beats start, dir is applied regardless.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      dir_d     = dir_q;
      step_en_d = 1'b0;
      cnt_clr_d = 1'b0;

      if (state_q == ST_RUN) begin
         presc_d = slot ? '0 : presc_q + PRESC_W'(1);
      end

      if (cmd.dir) begin
         dir_d = ~dir_q;
      end

      if (cmd.clear) begin
         state_d   = ST_IDLE;
         presc_d   = '0;
         cnt_clr_d = 1'b1;
      end else begin
         if (cmd.start) begin
            case (state_q)
               ST_IDLE: begin
                  state_d = ST_RUN;
                  presc_d = '0;
               end
               ST_RUN:   state_d = ST_PAUSE;
               ST_PAUSE: state_d = ST_RUN;
               default:  state_d = state_q;
            endcase
         end
         if (cmd.dir && (state_q == ST_DONE)) begin
            state_d = ST_PAUSE;
         end
         if (slot) begin
            if (step_ok) begin
               step_en_d = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
      end

      // While a step strobe is out, the direction pin shows the direction of that step.
      step_up_d = step_en_d ? dir_q : dir_d;
   end

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         dir_q     <= 1'b1;
         step_up_q <= 1'b1;
         step_en_q <= 1'b0;
         cnt_clr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         dir_q     <= dir_d;
         step_up_q <= step_up_d;
         step_en_q <= step_en_d;
         cnt_clr_q <= cnt_clr_d;
      end
   end

   assign step_en = step_en_q;
   assign step_up = step_up_q;
   assign cnt_clr = cnt_clr_q;
   assign state   = state_q;
   assign run_led = (state_q == ST_RUN);

endmodule
